// File: rtl/des_cbc_ctrl_if.sv
// Stream and DES-core signal bundle for the CBC chaining controller.
// The master modport is the controller side; slave is the environment side.
interface des_cbc_ctrl_if;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] core_din;
  logic        core_mode;
  logic        core_start;
  logic [63:0] core_dout;
  logic        core_valid;

  modport master (
    input  s_data, s_valid, m_ready, core_dout, core_valid,
    output s_ready, m_data, m_valid, core_din, core_mode, core_start
  );

  modport slave (
    output s_data, s_valid, m_ready, core_dout, core_valid,
    input  s_ready, m_data, m_valid, core_din, core_mode, core_start
  );
endinterface

// File: rtl/des_cbc_ctrl.sv
// CBC-mode chaining controller sitting between a block stream and an iterative DES core.
// One block in flight; the chaining register persists across blocks.
module des_cbc_ctrl #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [63:0]    iv,
  input  logic           iv_load,
  input  logic           mode,
  des_cbc_ctrl_if.master bus,
  output logic           busy,
  output logic           err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic [63:0]      chain;
  logic [63:0]      blk;
  logic [63:0]      din_r;
  logic [63:0]      dout_r;
  logic             mode_r;
  logic [CNT_W-1:0] cnt;

  // iv_load wins over a block offer so the new chaining value is in place first
  assign bus.s_ready    = (state == IDLE) && !iv_load;
  assign bus.core_start = (state == START);
  assign bus.m_valid    = (state == OUT);
  assign bus.core_din   = din_r;
  assign bus.core_mode  = mode_r;
  assign bus.m_data     = dout_r;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      chain  <= '0;
      blk    <= '0;
      din_r  <= '0;
      dout_r <= '0;
      mode_r <= 1'b0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iv_load) begin
            chain <= iv;
            err   <= 1'b0;
          end else if (bus.s_valid) begin
            blk    <= bus.s_data;
            mode_r <= mode;
            din_r  <= mode ? bus.s_data : (bus.s_data ^ chain);
            state  <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // decrypt un-chains with the previous ciphertext, then chains on this one
          if (bus.core_valid) begin
            dout_r <= mode_r ? (bus.core_dout ^ chain) : bus.core_dout;
            chain  <= mode_r ? blk : bus.core_dout;
            state  <= OUT;
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OUT: begin
          if (bus.m_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Bench for des_cbc_ctrl: DES core model, CBC reference model, vector table and corner sequences.
module tb_des_cbc_ctrl;
  localparam int LAT = 18;
  localparam int TO_SMALL = 8;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                              16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] din, input logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [47:0] e;
    logic [63:0] ipv, pre, res;
    logic [31:0] l, r, f, sout, tmp;
    logic [5:0]  six;
    int idx;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rn = 0; rn < 16; rn++) begin
      for (int k = 0; k < SH_T[rn]; k++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[rn][47-i] = cd[56-PC2_T[i]];
    end
    for (int i = 0; i < 64; i++) ipv[63-i] = din[64-IP_T[i]];
    l = ipv[63:32];
    r = ipv[31:0];
    for (int rn = 0; rn < 16; rn++) begin
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
      e = e ^ (dec ? ks[15-rn] : ks[rn]);
      for (int s = 0; s < 8; s++) begin
        six = e[47-6*s -: 6];
        idx = int'({six[5], six[0]}) * 16 + int'(six[4:1]);
        sout[31-4*s -: 4] = SBOX[s][255-4*idx -: 4];
      end
      for (int i = 0; i < 32; i++) f[31-i] = sout[32-P_T[i]];
      tmp = l ^ f;
      l = r;
      r = tmp;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
    return res;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] iv = '0;
  logic        iv_load = 1'b0;
  logic        mode = 1'b0;
  logic        busy, err;
  logic [63:0] iv2 = '0;
  logic        iv_load2 = 1'b0;
  logic        mode2 = 1'b0;
  logic        busy2, err2;

  des_cbc_ctrl_if bus ();
  des_cbc_ctrl_if bus2 ();

  des_cbc_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .iv(iv), .iv_load(iv_load), .mode(mode),
    .bus(bus), .busy(busy), .err(err));

  des_cbc_ctrl #(.TIMEOUT_CYC(TO_SMALL)) dut_to (
    .clk(clk), .rst_n(rst_n), .iv(iv2), .iv_load(iv_load2), .mode(mode2),
    .bus(bus2), .busy(busy2), .err(err2));

  // DES core model: result valid LAT+1 cycles after the start cycle, held hold_len cycles
  int          mcnt, vleft;
  int          hold_len = 1;
  logic [63:0] mdout;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt  <= 0;
      vleft <= 0;
      mdout <= '0;
    end else begin
      if (bus.core_start) begin
        mcnt  <= LAT;
        mdout <= des_ref(KEY, bus.core_din, bus.core_mode);
      end else if (mcnt != 0) mcnt <= mcnt - 1;
      if (mcnt == 1) vleft <= hold_len;
      else if (vleft != 0) vleft <= vleft - 1;
    end
  end
  assign bus.core_valid = (vleft != 0);
  assign bus.core_dout  = mdout;

  logic        extra_vld2 = 1'b0;
  logic [63:0] dout2 = '0;
  assign bus2.core_valid = extra_vld2;
  assign bus2.core_dout  = dout2;

  int          starts1 = 0, outs1 = 0, outs2 = 0;
  logic [63:0] last_din;
  logic        last_mode;
  always @(negedge clk) begin
    if (bus.core_start) begin
      starts1   <= starts1 + 1;
      last_din  <= bus.core_din;
      last_mode <= bus.core_mode;
    end
    if (bus.m_valid && bus.m_ready) outs1 <= outs1 + 1;
    if (bus2.m_valid) outs2 <= outs2 + 1;
  end

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CBC reference: plain chaining arithmetic over the DES model
  logic [63:0] ref_chain = '0;
  task automatic ref_step(input logic [63:0] data, input logic md,
                          output logic [63:0] edin, output logic [63:0] eout);
    if (!md) begin
      edin = data ^ ref_chain;
      eout = des_ref(KEY, edin, 1'b0);
      ref_chain = eout;
    end else begin
      edin = data;
      eout = des_ref(KEY, data, 1'b1) ^ ref_chain;
      ref_chain = data;
    end
  endtask

  task automatic load_iv(input logic [63:0] v);
    int w = 0;
    while (busy && w < 200) begin tick(); w++; end
    iv = v;
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    ref_chain = v;
  endtask

  task automatic run_block(input logic [63:0] data, input logic md, input bit bp, input bit poke,
                           output logic [63:0] din, output logic [63:0] out);
    int cyc, s0, o0;
    logic [63:0] held;
    cyc = 0;
    while (!bus.s_ready && cyc < 200) begin tick(); cyc++; end
    bus.m_ready = !bp;
    bus.s_data  = data;
    bus.s_valid = 1'b1;
    mode = md;
    s0 = starts1;
    o0 = outs1;
    tick();
    bus.s_valid = 1'b0;
    bus.s_data  = {$urandom, $urandom};
    mode = ~md;
    cyc = 1;
    while (!bus.m_valid && cyc < 200) begin
      if (poke && cyc == 3) begin iv = {$urandom, $urandom}; iv_load = 1'b1; end
      else iv_load = 1'b0;
      tick();
      cyc++;
    end
    iv_load = 1'b0;
    chk("latency", 64'(cyc), 64'(LAT + 3));
    chk("start_pulses", 64'(starts1 - s0), 64'd1);
    chk("core_mode", {63'd0, last_mode}, {63'd0, md});
    din = last_din;
    out = bus.m_data;
    if (bp) begin
      held = bus.m_data;
      for (int k = 0; k < 10; k++) begin
        tick();
        chk("bp_m_valid", {63'd0, bus.m_valid}, 64'd1);
        chk("bp_m_data", bus.m_data, held);
        chk("bp_s_ready", {63'd0, bus.s_ready}, 64'd0);
      end
      bus.m_ready = 1'b1;
    end
    tick();
    chk("m_valid_drop", {63'd0, bus.m_valid}, 64'd0);
    chk("s_ready_after", {63'd0, bus.s_ready}, 64'd1);
    chk("one_output", 64'(outs1 - o0), 64'd1);
  endtask

  task automatic do_block(input logic [63:0] data, input logic md, input bit bp, input bit poke,
                          output logic [63:0] din, output logic [63:0] out);
    logic [63:0] edin, eout;
    ref_step(data, md, edin, eout);
    run_block(data, md, bp, poke, din, out);
    chk("ref_core_din", din, edin);
    chk("ref_m_data", out, eout);
  endtask

  typedef struct {
    bit          ld;
    logic [63:0] ivv;
    logic        md;
    logic [63:0] data;
    logic [63:0] edin;
    logic [63:0] eout;
    bit          has_out;
  } vec_t;
  vec_t vt [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] din, out, d, v, x;
    logic [63:0] pts [4];
    logic [63:0] cts [4];
    int cyc;

    vt[0] = '{1'b1, 64'h0, 1'b0, PT, PT, CT, 1'b1};
    vt[1] = '{1'b1, PT, 1'b0, 64'h0, PT, CT, 1'b1};
    vt[2] = '{1'b0, 64'h0, 1'b0, CT, 64'h0, 64'h0, 1'b0};
    vt[3] = '{1'b1, 64'h0, 1'b1, CT, CT, PT, 1'b1};
    vt[4] = '{1'b0, 64'h0, 1'b0, 64'h84CB563386A179EA, PT, CT, 1'b1};

    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.m_ready = 1'b1;

    repeat (3) tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("rst_core_start", {63'd0, bus.core_start}, 64'd0);
    chk("rst_m_data", bus.m_data, 64'd0);
    chk("rst_core_din", bus.core_din, 64'd0);
    chk("rst_err2", {63'd0, err2}, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      if (vt[i].ld) load_iv(vt[i].ivv);
      do_block(vt[i].data, vt[i].md, 1'b0, 1'b0, din, out);
      chk($sformatf("vec%0d_din", i), din, vt[i].edin);
      if (vt[i].has_out) chk($sformatf("vec%0d_out", i), out, vt[i].eout);
    end

    // encrypt then decrypt under the same iv recovers the plaintexts
    v = {$urandom, $urandom};
    load_iv(v);
    for (int i = 0; i < 4; i++) begin
      pts[i] = {$urandom, $urandom};
      do_block(pts[i], 1'b0, 1'b0, 1'b0, din, cts[i]);
    end
    load_iv(v);
    for (int i = 0; i < 4; i++) begin
      do_block(cts[i], 1'b1, 1'b0, 1'b0, din, out);
      chk("roundtrip", out, pts[i]);
    end

    do_block({$urandom, $urandom}, 1'b0, 1'b1, 1'b0, din, out);

    for (int i = 0; i < 8; i++) begin
      hold_len = int'($urandom_range(1, 4));
      do_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
               bit'($urandom_range(0, 1)), din, out);
    end
    hold_len = 1;

    // simultaneous iv_load and s_valid: iv wins, block waits
    v = {$urandom, $urandom};
    d = {$urandom, $urandom};
    iv = v; iv_load = 1'b1; bus.s_valid = 1'b1; bus.s_data = d; mode = 1'b0;
    tick();
    chk("simul_not_accepted", {63'd0, busy}, 64'd0);
    iv_load = 1'b0; bus.s_valid = 1'b0;
    ref_chain = v;
    do_block(d, 1'b0, 1'b0, 1'b0, din, out);
    chk("simul_chain_iv", din, d ^ v);

    // reset while waiting on the core
    load_iv({$urandom, $urandom});
    bus.s_data = {$urandom, $urandom}; bus.s_valid = 1'b1; mode = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    repeat (5) tick();
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_core_start", {63'd0, bus.core_start}, 64'd0);
    chk("arst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("arst_core_din", bus.core_din, 64'd0);
    chk("arst_core_mode", {63'd0, bus.core_mode}, 64'd0);
    chk("arst_m_data", bus.m_data, 64'd0);
    tick();
    rst_n = 1'b1;
    ref_chain = '0;
    d = {$urandom, $urandom};
    do_block(d, 1'b0, 1'b0, 1'b0, din, out);
    chk("post_rst_chain0", din, d);

    // timeout on the short-timeout instance
    d = {$urandom, $urandom};
    bus2.s_data = d; bus2.s_valid = 1'b1; mode2 = 1'b0;
    tick();
    bus2.s_valid = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 100) begin tick(); cyc++; end
    chk("timeout_cycles", 64'(cyc), 64'(TO_SMALL + 1));
    chk("timeout_err", {63'd0, err2}, 64'd1);
    chk("timeout_no_out", 64'(outs2), 64'd0);
    extra_vld2 = 1'b1; dout2 = {$urandom, $urandom};
    repeat (2) tick();
    extra_vld2 = 1'b0;
    tick();
    chk("late_valid_idle", {63'd0, busy2}, 64'd0);
    chk("late_valid_no_out", 64'(outs2), 64'd0);
    chk("err_sticky", {63'd0, err2}, 64'd1);

    // processing continues with err set; chain untouched by the aborted block
    d = {$urandom, $urandom};
    x = {$urandom, $urandom};
    bus2.s_data = d; bus2.s_valid = 1'b1; mode2 = 1'b0;
    tick();
    bus2.s_valid = 1'b0;
    tick();
    extra_vld2 = 1'b1; dout2 = x;
    tick();
    extra_vld2 = 1'b0;
    chk("err_run_m_valid", {63'd0, bus2.m_valid}, 64'd1);
    chk("err_run_m_data", bus2.m_data, x);
    chk("err_run_core_din", bus2.core_din, d);
    chk("err_run_err", {63'd0, err2}, 64'd1);
    tick();
    chk("err_run_drop", {63'd0, bus2.m_valid}, 64'd0);
    iv2 = {$urandom, $urandom}; iv_load2 = 1'b1;
    tick();
    iv_load2 = 1'b0;
    chk("iv_load_clears_err", {63'd0, err2}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/des_cbc_ctrl.md
Name: des_cbc_ctrl

Overview:
- CBC-mode chaining controller on the host side of the iterative DES core.
- Accepts 64-bit blocks from an upstream valid/ready stream and XORs them with the chaining value.
- Drives the core's start/din/mode inputs, collects the core result on its valid, and returns the chained result on a downstream valid/ready stream.
- Handles one block in flight at a time; the chaining register carries state across blocks.

Parameters:
- TIMEOUT_CYC, 64: cycles spent in WAIT without core_valid before the block is aborted and err is raised. Range 2..1023.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- iv  input  64  initialisation vector
- iv_load  input  1  load iv into the chaining register and clear err; honoured in IDLE only
- mode  input  1  0 = encrypt, 1 = decrypt; sampled at block accept
- s_data  input  64  input block
- s_valid  input  1  input block valid
- s_ready  output  1  controller can accept a block
- m_data  output  64  result block
- m_valid  output  1  result valid
- m_ready  input  1  downstream accepts result
- core_din  output  64  block to the DES core
- core_mode  output  1  mode to the DES core
- core_start  output  1  one-cycle start pulse to the DES core
- core_dout  input  64  DES core result
- core_valid  input  1  DES core result valid
- busy  output  1  state != IDLE
- err  output  1  sticky timeout flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; chain, core_din, m_data, held block and timeout counter = 0.
  - core_mode = 0, core_start = 0, m_valid = 0, err = 0, busy = 0.
  - s_ready is combinational and may read 1, but no transfer is accepted while rst_n is low.
- State machine: IDLE -> START -> WAIT -> OUT -> IDLE. WAIT also exits to IDLE on timeout.
- s_ready = (state == IDLE) && !iv_load.
- iv_load in IDLE: chain <= iv, err <= 0. iv_load in any other state is ignored.
- IDLE, on s_valid && s_ready:
  - Latch the block into blk and mode into core_mode.
  - Encrypt: core_din <= s_data ^ chain.
  - Decrypt: core_din <= s_data.
  - Go to START.
- START:
  - core_start = 1 for exactly this cycle.
  - core_din and core_mode stay stable from here until WAIT exits.
  - Clear the timeout counter and go to WAIT.
- WAIT, first cycle with core_valid = 1:
  - Encrypt: m_data <= core_dout, chain <= core_dout.
  - Decrypt: m_data <= core_dout ^ chain, chain <= blk.
  - Go to OUT.
- WAIT timeout: counter reaching TIMEOUT_CYC-1 with no core_valid sets err = 1 and returns to IDLE. chain is unchanged and no output is produced.
- OUT:
  - m_valid = 1; m_data is held stable while m_ready = 0.
  - On m_ready, go to IDLE; m_valid drops the next cycle.
- core_valid is ignored outside WAIT. A level-held core_valid is consumed only once.
- Latency: accept at cycle 0, core_start at cycle 1, m_valid one cycle after the first core_valid seen in WAIT.
- Minimum block period with m_ready tied 1 is core latency + 4 cycles.
- mode or iv changes after accept do not affect the block in flight.
- err is sticky: cleared only by reset or iv_load. Processing continues normally while err = 1.
- rst_n low mid-block aborts immediately. core_start deasserts, and the next block uses chain = 0 unless iv_load is applied.

Test Plan:
- Core model: key 133457799BBCDFF1, fixed latency 18. Encrypt with iv = 0, s_data = 0123456789ABCDEF -> core_din = 0123456789ABCDEF, single core_start pulse, m_data = 85E813540F0AB405, chain = 85E813540F0AB405.
- Encrypt with iv = 0123456789ABCDEF, s_data = 0 -> core_din = 0123456789ABCDEF, m_data = 85E813540F0AB405. Then a second block s_data = 85E813540F0AB405 -> core_din = 0.
- Decrypt with iv = 0, s_data = 85E813540F0AB405 -> m_data = 0123456789ABCDEF, chain = 85E813540F0AB405. Encrypt-then-decrypt round trip of 4 random blocks -> outputs match the original plaintexts.
- Backpressure: hold m_ready = 0 for 10 cycles in OUT -> m_valid = 1 and m_data stable throughout, s_ready = 0. Assert m_ready -> IDLE; s_ready = 1 the following cycle.
- Timeout with TIMEOUT_CYC = 8 and core_valid never asserted -> err = 1, no m_valid, back in IDLE. iv_load -> err = 0. A late core_valid while in IDLE -> no effect.
- Reset asserted in WAIT -> all outputs at reset values immediately. Simultaneous iv_load and s_valid in IDLE -> block not accepted that cycle, chain = iv.
